dco_tune_seq: RTL
=================

Name: dco_tune_seq

Overview:
- Sequencer that sits between the ADPLL loop / calibration logic and the DCO capacitor-bank row/column coder.
- Accepts a target tuning word through a valid/ready handshake.
- Slews the coder word toward the target in bounded steps, issuing one coder-enable pulse per step and waiting a programmable settle time between steps.
- Bounds each bank update to limit DCO frequency glitches during large retunes.

Parameters:
- WORD_W, 8, width of tuning word (matches coder WORD_W).
- ROW_W, 4, log2 of rows/cols in bank; word>>ROW_W is the row index.
- MAX_STEP, 4, maximum absolute change of cod_word per update; 1 <= MAX_STEP < 2^WORD_W.
- SETTLE_W, 4, width of settle-count configuration.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tgt_valid  in  1  target word offered
- tgt_word  in  WORD_W  requested tuning word
- tgt_ready  out  1  sequencer can accept a target
- settle_cfg  in  SETTLE_W  extra wait cycles after each update; sampled at accept
- bypass  in  1  apply target in one update, no step limit; sampled at accept
- cod_en  out  1  one-cycle enable to coder; cod_word is valid while high
- cod_word  out  WORD_W  word driven to coder (registered)
- row_cross  out  1  pulses with cod_en when the update changes cod_word>>ROW_W
- busy  out  1  high while in STEP or SETTLE
- done  out  1  one-cycle pulse when cod_word has reached the accepted target

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-slew:
  - cod_word = 1<<(WORD_W-1) (128 for WORD_W=8), which is the bank's half-on state.
  - cod_en, row_cross, done, busy = 0; tgt_ready = 1; state = IDLE; settle counter = 0.
- FSM states: IDLE, STEP, SETTLE. All outputs are registered except tgt_ready and busy, which decode from state.
- IDLE:
  - tgt_ready = 1.
  - On an edge with tgt_valid & tgt_ready, latch tgt_word, settle_cfg and bypass.
  - If the latched target equals cod_word: pulse done in the next cycle and stay in IDLE.
  - Otherwise go to STEP.
- STEP (exactly 1 cycle):
  - diff = target - cod_word, computed signed at WORD_W+1 bits.
  - next = target if bypass or |diff| <= MAX_STEP; otherwise cod_word + MAX_STEP (diff > 0) or cod_word - MAX_STEP (diff < 0).
  - At the exit edge: cod_word <= next, cod_en <= 1 for exactly one cycle, row_cross <= ((next>>ROW_W) != (cod_word>>ROW_W)).
  - Load the settle counter with the latched settle_cfg and go to SETTLE.
- SETTLE (lasts settle_cfg+1 cycles):
  - Counter decrements each cycle.
  - When the counter is 0: if cod_word == target, pulse done and go to IDLE; otherwise go to STEP.
- Timing:
  - Update period = settle_cfg+2 cycles.
  - First cod_en asserts 2 cycles after the accept edge.
  - done is concurrent with the return to IDLE; tgt_ready is high in that same cycle.
- Arithmetic and range:
  - cod_word never wraps and never overshoots the target; intermediate values stay between the start word and the target.
  - Word 0 and word 2^WORD_W-1 are legal targets.
- While busy:
  - tgt_ready = 0; tgt_valid is ignored and the offered word is not latched.
  - Changes on settle_cfg or bypass have no effect until the next accept.
- done and cod_en never assert in the same cycle, except when the final step is the only step and settle_cfg=0; they still remain in separate cycles because SETTLE lasts at least 1 cycle.

Test Plan:
1. Reset → cod_word=128, cod_en=0, done=0, busy=0, tgt_ready=1; assert rst asynchronously mid-cycle and confirm outputs clear without a clock edge.
2. MAX_STEP=4, settle_cfg=2, target 140 from 128 → cod_en pulses once every 4 cycles with cod_word 132, 136, 140; row_cross=0 throughout; done 3 cycles after the last cod_en; busy high from cycle after accept until done.
3. Start 130, target 120 → updates 126 (row_cross=1, row 8→7), 122, 120 (last step 2); done pulse; exactly 3 cod_en pulses.
4. Target equal to current word (128) → done 1 cycle after accept, no cod_en, busy stays 0; bypass=1, target 255 → single update to 255 with row_cross=1, then done after settle.
5. Hold tgt_valid with tgt_word=0 while busy slewing to 140 → word not accepted until tgt_ready returns; afterward slew 140→0 by −4 steps down to exactly 0, no wrap.
6. Assert rst during SETTLE of a slew to 200 → immediate return to cod_word=128, IDLE, no done pulse; a subsequent accept restarts normally.

Source files
------------

// File: rtl/dco_tune_seq_if.sv
// dco_tune_seq_if
//   Target-word handshake between the ADPLL loop / calibration logic
//   (master) and the DCO tuning sequencer (slave).
//
//   tgt_valid  master -> slave  target word offered
//   tgt_word   master -> slave  requested tuning word
//   tgt_ready  slave -> master  sequencer can accept a target
interface dco_tune_seq_if #(
  parameter int WORD_W = 8
);
  logic              tgt_valid;
  logic [WORD_W-1:0] tgt_word;
  logic              tgt_ready;

  modport master (
    output tgt_valid,
    output tgt_word,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_word,
    output tgt_ready
  );
endinterface

// File: rtl/dco_tune_seq.sv
// dco_tune_seq
//   Slews the DCO capacitor-bank coder word toward an accepted target in
//   steps of at most MAX_STEP. Each step produces one cod_en pulse; a
//   programmable settle wait separates consecutive steps so that a large
//   retune never disturbs the DCO by more than one bounded bank update.
//
//   clk         clock
//   rst         asynchronous, active-high reset
//   tgt         target handshake (slave side): tgt_valid, tgt_word, tgt_ready
//   settle_cfg  extra wait cycles after each update, sampled at accept
//   bypass      apply the target in a single update, sampled at accept
//   cod_en      one-cycle coder enable, cod_word valid while high
//   cod_word    registered word driven to the coder
//   row_cross   pulses with cod_en when the update changes the row index
//   busy        high while stepping or settling
//   done        one-cycle pulse when cod_word reaches the accepted target
//
//   state  | meaning
//   IDLE   | ready for a target; cod_word holds its last value
//   STEP   | one cycle: compute and apply the next bounded update
//   SETTLE | wait settle_cfg+1 cycles for the DCO to settle
module dco_tune_seq #(
  parameter int WORD_W   = 8,
  parameter int ROW_W    = 4,
  parameter int MAX_STEP = 4,
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  dco_tune_seq_if.slave       tgt,
  input  logic [SETTLE_W-1:0] settle_cfg,
  input  logic                bypass,
  output logic                cod_en,
  output logic [WORD_W-1:0]   cod_word,
  output logic                row_cross,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  // Half-on bank: MSB set, all other bits clear.
  localparam logic [WORD_W-1:0] HALF_WORD = {1'b1, {(WORD_W-1){1'b0}}};
  localparam logic [WORD_W:0]   STEP_MAG  = (WORD_W+1)'(MAX_STEP);
  localparam logic [WORD_W-1:0] STEP_INC  = WORD_W'(MAX_STEP);

  logic [1:0]          state;
  logic [WORD_W-1:0]   tgt_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                bypass_q;
  logic [SETTLE_W-1:0] settle_cnt;

  logic signed [WORD_W:0] diff;
  logic [WORD_W:0]        diff_mag;
  logic [WORD_W-1:0]      next_word;

  assign tgt.tgt_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  // The extra sign bit keeps the difference exact over the full word range,
  // so a full-scale step can never be mistaken for a small one. A limited
  // step is only taken when |diff| > MAX_STEP, which rules out wrap and
  // overshoot.
  always_comb begin
    diff      = $signed({1'b0, tgt_q}) - $signed({1'b0, cod_word});
    diff_mag  = diff[WORD_W] ? $unsigned(-diff) : $unsigned(diff);
    next_word = tgt_q;
    if (!bypass_q && (diff_mag > STEP_MAG)) begin
      if (diff[WORD_W]) begin
        next_word = cod_word - STEP_INC;
      end else begin
        next_word = cod_word + STEP_INC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cod_word   <= HALF_WORD;
      cod_en     <= 1'b0;
      row_cross  <= 1'b0;
      done       <= 1'b0;
      settle_cnt <= '0;
      tgt_q      <= HALF_WORD;
      settle_q   <= '0;
      bypass_q   <= 1'b0;
    end else begin
      cod_en    <= 1'b0;
      row_cross <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt.tgt_valid && tgt.tgt_ready) begin
            tgt_q    <= tgt.tgt_word;
            settle_q <= settle_cfg;
            bypass_q <= bypass;
            if (tgt.tgt_word == cod_word) begin
              done <= 1'b1;
            end else begin
              state <= STEP;
            end
          end
        end
        STEP: begin
          cod_word   <= next_word;
          cod_en     <= 1'b1;
          row_cross  <= ((next_word >> ROW_W) != (cod_word >> ROW_W));
          settle_cnt <= settle_q;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            if (cod_word == tgt_q) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= STEP;
            end
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
